// File: rtl/mult_acc16.sv
// mult_acc16: sums groups of N products into a 2-entry result FIFO.
// Define MULT_ACC16_SAT_EN to clamp group sums on carry instead of wrapping.
module mult_acc16 #(
  parameter int N     = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [7:0]       count,
  output logic             overflow,
  output logic             overrun
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum;
  logic             carry, accept, last;
  logic [ACC_W-1:0] head_q, tail_q;
  logic [1:0]       occ_q;
  logic             ovf_q, ovr_q;
  logic             pop, full, push_ok;

  assign accept   = prod_valid && !clear;
  assign last     = accept && (cnt_q == 8'(N - 1));
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;
  assign sum_wide = {1'b0, acc_base} + (ACC_W + 1)'(prod);
  assign carry    = sum_wide[ACC_W];

`ifdef MULT_ACC16_SAT_EN
  assign sum = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign sum = sum_wide[ACC_W-1:0];
`endif

  assign pop     = acc_valid && acc_ready;
  assign full    = (occ_q == 2'd2);
  assign push_ok = last && (!full || pop);

  assign acc_out   = head_q;
  assign acc_valid = (occ_q != 2'd0);
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign overrun   = ovr_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a group closes on its last product or on clear
  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (accept) state_d = last ? IDLE : ACC;
  end

  // Accumulator and count update for this cycle
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear || last) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Accumulator, count and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (accept && carry)      ovf_q <= 1'b1;
      if (last && full && !pop) ovr_q <= 1'b1;
    end
  end

  // Two-entry FIFO: head feeds acc_out directly
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else if (pop && push_ok) begin
      if (occ_q == 2'd1) begin
        head_q <= sum;
      end else begin
        head_q <= tail_q;
        tail_q <= sum;
      end
    end else if (pop) begin
      head_q <= tail_q;
      occ_q  <= occ_q - 2'd1;
    end else if (push_ok) begin
      if (occ_q == 2'd0) head_q <= sum;
      else               tail_q <= sum;
      occ_q <= occ_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_mult_acc16.sv
// tb_mult_acc16: directed checks on four parameterisations
// sharing one stimulus stream.
module tb_mult_acc16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] prod = '0;
  logic        prod_valid = 1'b0;
  logic        clear = 1'b0;
  logic        acc_ready = 1'b1;

  logic [39:0] out4, out16, out2;
  logic [31:0] outw;
  logic        v4, v16, v2, vw;
  logic [7:0]  c4, c16, c2, cw;
  logic        of4, of16, of2, ofw;
  logic        or4, or16, or2, orw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_acc16 #(.N(4), .ACC_W(40)) u4 (
    .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
    .clear(clear), .acc_out(out4), .acc_valid(v4), .acc_ready(acc_ready),
    .count(c4), .overflow(of4), .overrun(or4));

  mult_acc16 #(.N(16), .ACC_W(40)) u16 (
    .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
    .clear(clear), .acc_out(out16), .acc_valid(v16), .acc_ready(acc_ready),
    .count(c16), .overflow(of16), .overrun(or16));

  mult_acc16 #(.N(2), .ACC_W(40)) u2 (
    .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
    .clear(clear), .acc_out(out2), .acc_valid(v2), .acc_ready(acc_ready),
    .count(c2), .overflow(of2), .overrun(or2));

  mult_acc16 #(.N(2), .ACC_W(32)) uw (
    .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
    .clear(clear), .acc_out(outw), .acc_valid(vw), .acc_ready(acc_ready),
    .count(cw), .overflow(ofw), .overrun(orw));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    prod_valid = 1'b0;
    clear = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic feed(input logic [31:0] p);
    prod = p;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out4 !== 40'd0) begin
      errors++; $display("FAIL reset_acc_out got %0h want 0", out4);
    end
    checks++;
    if ({v4, of4, or4} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {v4, of4, or4});
    end
    checks++;
    if (c4 !== 8'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", c4);
    end
  endtask

  task automatic test_basic_group();
    logic [7:0] exp_cnt [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
    do_reset();
    acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(32'(i + 1));
      checks++;
      if (c4 !== exp_cnt[i]) begin
        errors++; $display("FAIL basic_count[%0d] got %0d want %0d", i, c4, exp_cnt[i]);
      end
      checks++;
      if (v4 !== (i == 3)) begin
        errors++; $display("FAIL basic_valid[%0d] got %b want %b", i, v4, i == 3);
      end
    end
    checks++;
    if (out4 !== 40'd10) begin
      errors++; $display("FAIL basic_sum got %0d want 10", out4);
    end
    tick();
    checks++;
    if (v4 !== 1'b0) begin
      errors++; $display("FAIL basic_valid_drop got %b want 0", v4);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    acc_ready = 1'b1;
    prod = 32'hFFFE0001;
    prod_valid = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 16 || i == 32) begin
        checks++;
        if (v16 !== 1'b1 || out16 !== 40'hF_FFE0_0010) begin
          errors++; $display("FAIL b2b_sum[%0d] got v=%b %0h want v=1 ffffe00010", i, v16, out16);
        end
      end
      if (i == 17) begin
        checks++;
        if (c16 !== 8'd1 || v16 !== 1'b0) begin
          errors++; $display("FAIL b2b_nobubble got count=%0d v=%b want 1 0", c16, v16);
        end
      end
    end
    prod_valid = 1'b0;
    checks++;
    if (of16 !== 1'b0 || c16 !== 8'd0) begin
      errors++; $display("FAIL b2b_end got ovf=%b count=%0d want 0 0", of16, c16);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ps [6] = '{32'd2, 32'd3, 32'd3, 32'd4, 32'd4, 32'd5};
    do_reset();
    acc_ready = 1'b0;
    for (int i = 0; i < 6; i++) feed(ps[i]);
    checks++;
    if (v2 !== 1'b1 || out2 !== 40'd5 || or2 !== 1'b1) begin
      errors++; $display("FAIL bp_full got v=%b out=%0d ovr=%b want 1 5 1", v2, out2, or2);
    end
    acc_ready = 1'b1;
    tick();
    checks++;
    if (v2 !== 1'b1 || out2 !== 40'd7) begin
      errors++; $display("FAIL bp_second got v=%b out=%0d want 1 7", v2, out2);
    end
    tick();
    checks++;
    if (v2 !== 1'b0 || or2 !== 1'b1) begin
      errors++; $display("FAIL bp_empty got v=%b ovr=%b want 0 1", v2, or2);
    end
  endtask

  task automatic test_clear();
    do_reset();
    acc_ready = 1'b1;
    feed(32'd100);
    feed(32'd200);
    clear = 1'b1;
    feed(32'd300);
    clear = 1'b0;
    checks++;
    if (c4 !== 8'd0 || v4 !== 1'b0) begin
      errors++; $display("FAIL clear_count got %0d v=%b want 0 0", c4, v4);
    end
    for (int i = 0; i < 4; i++) feed(32'd1);
    checks++;
    if (v4 !== 1'b1 || out4 !== 40'd4) begin
      errors++; $display("FAIL clear_sum got v=%b out=%0d want 1 4", v4, out4);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sum;
`ifdef MULT_ACC16_SAT_EN
    exp_sum = 32'hFFFFFFFF;
`else
    exp_sum = 32'd1;
`endif
    do_reset();
    acc_ready = 1'b1;
    feed(32'hFFFFFFFF);
    checks++;
    if (ofw !== 1'b0) begin
      errors++; $display("FAIL ovf_early got %b want 0", ofw);
    end
    feed(32'd2);
    checks++;
    if (ofw !== 1'b1 || vw !== 1'b1 || outw !== exp_sum) begin
      errors++; $display("FAIL ovf_sum got ovf=%b v=%b out=%0h want 1 1 %0h", ofw, vw, outw, exp_sum);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    acc_ready = 1'b0;
    for (int i = 0; i < 15; i++) feed(32'd1);
    checks++;
    if (v4 !== 1'b1 || c4 !== 8'd3 || or4 !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got v=%b count=%0d ovr=%b want 1 3 1", v4, c4, or4);
    end
    prod = 32'd1;
    prod_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prod_valid = 1'b0;
    checks++;
    if (v4 !== 1'b0 || c4 !== 8'd0 || or4 !== 1'b0 || of4 !== 1'b0) begin
      errors++; $display("FAIL rmid_post got v=%b count=%0d ovr=%b ovf=%b want 0 0 0 0", v4, c4, or4, of4);
    end
    acc_ready = 1'b1;
    for (int i = 5; i <= 8; i++) feed(32'(i));
    checks++;
    if (v4 !== 1'b1 || out4 !== 40'd26) begin
      errors++; $display("FAIL rmid_sum got v=%b out=%0d want 1 26", v4, out4);
    end
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
